// File: rtl/wb_b3_pkg.sv
// Shared Wishbone B3 constants and the RAM arbiter state encoding.
package wb_b3_pkg;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_CONST   = 3'b001;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;

   localparam logic [1:0] BTE_LIN    = 2'b00;
   localparam logic [1:0] BTE_WRAP4  = 2'b01;
   localparam logic [1:0] BTE_WRAP8  = 2'b10;
   localparam logic [1:0] BTE_WRAP16 = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } arb_state_e;

endpackage

// File: rtl/wb_bus_watchdog.sv
// Stall counter for the granted master; flags the cycle a strobe has waited TIMEOUT cycles.
module wb_bus_watchdog #(
   parameter int unsigned TIMEOUT = 64
) (
   input  logic wb_clk_i,
   input  logic wb_rst_ni,
   input  logic active,
   input  logic stb,
   input  logic resp,
   input  logic restart,
   output logic expire_c
);

   localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   logic [CW-1:0] wdt;
   logic          hit;

   assign hit      = (TIMEOUT != 0) && (wdt == CW'(TIMEOUT));
   // A slave response landing on the terminal cycle wins over the watchdog.
   assign expire_c = active && stb && hit && !resp;

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_ni) begin
         wdt <= '0;
      end else if (restart || !active || !stb || resp || hit) begin
         wdt <= '0;
      end else if (wdt != CW'(TIMEOUT)) begin
         wdt <= wdt + 1'b1;
      end
   end

endmodule

// File: rtl/wb_b3_ram_arbiter.sv
// Two-master Wishbone B3 arbiter for the on-chip RAM port: cycle-held grant,
// round-robin idle pick and a stall watchdog that errors out a hung slave.
module wb_b3_ram_arbiter
   import wb_b3_pkg::*;
#(
   parameter int unsigned dw      = 32,
   parameter int unsigned aw      = 32,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_ni,
   input  logic [aw-1:0]     m0_adr_i,
   input  logic [dw-1:0]     m0_dat_i,
   input  logic [dw/8-1:0]   m0_sel_i,
   input  logic              m0_we_i,
   input  logic [1:0]        m0_bte_i,
   input  logic [2:0]        m0_cti_i,
   input  logic              m0_cyc_i,
   input  logic              m0_stb_i,
   output logic              m0_ack_o,
   output logic              m0_err_o,
   output logic              m0_rty_o,
   output logic [dw-1:0]     m0_dat_o,
   input  logic [aw-1:0]     m1_adr_i,
   input  logic [dw-1:0]     m1_dat_i,
   input  logic [dw/8-1:0]   m1_sel_i,
   input  logic              m1_we_i,
   input  logic [1:0]        m1_bte_i,
   input  logic [2:0]        m1_cti_i,
   input  logic              m1_cyc_i,
   input  logic              m1_stb_i,
   output logic              m1_ack_o,
   output logic              m1_err_o,
   output logic              m1_rty_o,
   output logic [dw-1:0]     m1_dat_o,
   output logic [aw-1:0]     s_adr_o,
   output logic [dw-1:0]     s_dat_o,
   output logic [dw/8-1:0]   s_sel_o,
   output logic              s_we_o,
   output logic [1:0]        s_bte_o,
   output logic [2:0]        s_cti_o,
   output logic              s_cyc_o,
   output logic              s_stb_o,
   input  logic              s_ack_i,
   input  logic              s_err_i,
   input  logic              s_rty_i,
   input  logic [dw-1:0]     s_dat_i
);

   arb_state_e state_q, state_d;
   logic       last_gnt_q, last_gnt_d;
   logic       kill_q, kill_d;
   logic       restart;
   logic       gnt0, gnt1, granted;
   logic       g_cyc, g_stb, gate;
   logic       expire_c;

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_ni) begin
         state_q    <= IDLE;
         last_gnt_q <= 1'b1;
         kill_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_gnt_q <= last_gnt_d;
         kill_q     <= kill_d;
      end
   end

   // Grant is only released when the owner drops cyc; handover is zero-gap.
   always_comb begin
      state_d    = state_q;
      last_gnt_d = last_gnt_q;
      kill_d     = kill_q;
      case (state_q)
         IDLE: begin
            if (m0_cyc_i && m1_cyc_i) state_d = last_gnt_q ? GNT0 : GNT1;
            else if (m0_cyc_i)        state_d = GNT0;
            else if (m1_cyc_i)        state_d = GNT1;
         end
         GNT0: begin
            if (!m0_cyc_i) begin
               last_gnt_d = 1'b0;
               state_d    = m1_cyc_i ? GNT1 : IDLE;
            end
         end
         GNT1: begin
            if (!m1_cyc_i) begin
               last_gnt_d = 1'b1;
               state_d    = m0_cyc_i ? GNT0 : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      restart = (state_d != state_q);
      // Once the watchdog fires, the slave is cut off until the owner ends its cycle.
      if (!granted || !g_cyc || restart) kill_d = 1'b0;
      else if (expire_c)                 kill_d = 1'b1;
   end

   assign gnt0    = wb_rst_ni && (state_q == GNT0);
   assign gnt1    = wb_rst_ni && (state_q == GNT1);
   assign granted = gnt0 || gnt1;
   assign g_cyc   = gnt1 ? m1_cyc_i : m0_cyc_i;
   assign g_stb   = gnt1 ? m1_stb_i : m0_stb_i;
   assign gate    = kill_q || expire_c;

   wb_bus_watchdog #(.TIMEOUT(TIMEOUT)) u_wdt (
      .wb_clk_i  (wb_clk_i),
      .wb_rst_ni (wb_rst_ni),
      .active    (granted && !kill_q),
      .stb       (g_stb),
      .resp      (s_ack_i || s_err_i || s_rty_i),
      .restart   (restart),
      .expire_c  (expire_c)
   );

   assign s_adr_o = gnt1 ? m1_adr_i : m0_adr_i;
   assign s_dat_o = gnt1 ? m1_dat_i : m0_dat_i;
   assign s_sel_o = gnt1 ? m1_sel_i : m0_sel_i;
   assign s_bte_o = gnt1 ? m1_bte_i : m0_bte_i;
   assign s_cti_o = gnt1 ? m1_cti_i : m0_cti_i;
   assign s_we_o  = (gnt0 && m0_we_i) || (gnt1 && m1_we_i);
   assign s_cyc_o = granted && g_cyc && !gate;
   assign s_stb_o = granted && g_stb && !gate;

   assign m0_ack_o = gnt0 && s_ack_i;
   assign m0_err_o = gnt0 && (s_err_i || expire_c);
   assign m0_rty_o = gnt0 && s_rty_i;
   assign m1_ack_o = gnt1 && s_ack_i;
   assign m1_err_o = gnt1 && (s_err_i || expire_c);
   assign m1_rty_o = gnt1 && s_rty_i;
   assign m0_dat_o = s_dat_i;
   assign m1_dat_o = s_dat_i;

endmodule

// File: tb/tb_wb_b3_ram_arbiter.sv
// Bench for wb_b3_ram_arbiter: directed scenarios plus random traffic against an ownership model.
module tb_wb_b3_ram_arbiter;
   import wb_b3_pkg::*;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 32;
   localparam int unsigned SW = 4;
   localparam int unsigned TO = 8;

   logic          wb_clk_i = 1'b0;
   logic          wb_rst_ni;
   logic [AW-1:0] adr  [2];
   logic [DW-1:0] wdat [2];
   logic [SW-1:0] sel  [2];
   logic [1:0]    bte  [2];
   logic [2:0]    cti  [2];
   logic [1:0]    we, cyc, stb, ack_o, err_o, rty_o;
   logic [DW-1:0] m0_dat, m1_dat;
   logic [AW-1:0] s_adr;
   logic [DW-1:0] s_dat_o, s_dat_i;
   logic [SW-1:0] s_sel;
   logic [1:0]    s_bte;
   logic [2:0]    s_cti;
   logic          s_we, s_cyc, s_stb, s_ack, s_err, s_rty;

   int vectors = 0;
   int miscompares = 0;
   // Reference model: who owns the slave, who was served last, stall length, cut-off flag.
   int own = -1;
   int last = 1;
   int stall = 0;
   bit killed = 1'b0;
   bit cur_tmo = 1'b0;

   always #5 wb_clk_i = ~wb_clk_i;

   wb_b3_ram_arbiter #(.dw(DW), .aw(AW), .TIMEOUT(TO)) dut (
      .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni),
      .m0_adr_i(adr[0]), .m0_dat_i(wdat[0]), .m0_sel_i(sel[0]), .m0_we_i(we[0]),
      .m0_bte_i(bte[0]), .m0_cti_i(cti[0]), .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]),
      .m0_ack_o(ack_o[0]), .m0_err_o(err_o[0]), .m0_rty_o(rty_o[0]), .m0_dat_o(m0_dat),
      .m1_adr_i(adr[1]), .m1_dat_i(wdat[1]), .m1_sel_i(sel[1]), .m1_we_i(we[1]),
      .m1_bte_i(bte[1]), .m1_cti_i(cti[1]), .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]),
      .m1_ack_o(ack_o[1]), .m1_err_o(err_o[1]), .m1_rty_o(rty_o[1]), .m1_dat_o(m1_dat),
      .s_adr_o(s_adr), .s_dat_o(s_dat_o), .s_sel_o(s_sel), .s_we_o(s_we),
      .s_bte_o(s_bte), .s_cti_o(s_cti), .s_cyc_o(s_cyc), .s_stb_o(s_stb),
      .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty), .s_dat_i(s_dat_i)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Compare every output against the model for the current cycle.
   task automatic check_cycle();
      logic       e_cyc, e_stb, e_we, resp;
      logic [1:0] e_ack, e_err, e_rty;
      @(negedge wb_clk_i);
      e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0;
      e_ack = 2'b00; e_err = 2'b00; e_rty = 2'b00;
      cur_tmo = 1'b0;
      resp = s_ack | s_err | s_rty;
      if (wb_rst_ni && own >= 0) begin
         cur_tmo = !killed && stb[own] && (stall == int'(TO)) && !resp;
         e_cyc = cyc[own] && !killed && !cur_tmo;
         e_stb = stb[own] && !killed && !cur_tmo;
         e_we  = we[own];
         e_ack[own] = s_ack;
         e_err[own] = s_err | cur_tmo;
         e_rty[own] = s_rty;
         chk("s_adr", s_adr, adr[own]);
         chk("s_dat_o", s_dat_o, wdat[own]);
         chk("s_sel", 32'(s_sel), 32'(sel[own]));
         chk("s_cti", 32'(s_cti), 32'(cti[own]));
         chk("s_bte", 32'(s_bte), 32'(bte[own]));
      end
      chk("s_cyc", 32'(s_cyc), 32'(e_cyc));
      chk("s_stb", 32'(s_stb), 32'(e_stb));
      chk("s_we", 32'(s_we), 32'(e_we));
      chk("ack", 32'(ack_o), 32'(e_ack));
      chk("err", 32'(err_o), 32'(e_err));
      chk("rty", 32'(rty_o), 32'(e_rty));
      chk("m0_dat", m0_dat, s_dat_i);
      chk("m1_dat", m1_dat, s_dat_i);
   endtask

   // Clock edge: advance the model with the inputs that were present.
   task automatic advance();
      logic resp;
      @(posedge wb_clk_i);
      resp = s_ack | s_err | s_rty;
      if (!wb_rst_ni) begin
         own = -1; last = 1; stall = 0; killed = 1'b0;
      end else if (own < 0) begin
         if (cyc == 2'b11) own = 1 - last;
         else if (cyc[0])  own = 0;
         else if (cyc[1])  own = 1;
         stall = 0;
      end else if (!cyc[own]) begin
         last = own;
         own = cyc[1-own] ? 1 - own : -1;
         stall = 0; killed = 1'b0;
      end else if (cur_tmo) begin
         killed = 1'b1; stall = 0;
      end else if (killed || !stb[own] || resp) begin
         stall = 0;
      end else begin
         stall++;
      end
      #1;
   endtask

   task automatic tick();
      check_cycle();
      advance();
   endtask

   initial begin
      int prev, got;
      bit stall_mode;
      for (int i = 0; i < 2; i++) begin
         adr[i] = '0; wdat[i] = '0; sel[i] = 4'hF; bte[i] = BTE_LIN; cti[i] = CTI_CLASSIC;
      end
      we = 2'b00; cyc = 2'b00; stb = 2'b00;
      s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0; s_dat_i = 32'h0;
      wb_rst_ni = 1'b0;
      #1;
      repeat (2) tick();
      wb_rst_ni = 1'b1;

      // 1: reset asserted for 3 cycles in the middle of an m0 burst
      adr[0] = 32'h100; cti[0] = CTI_CONST; bte[0] = BTE_WRAP4; cyc = 2'b01; stb = 2'b01;
      tick();
      s_ack = 1'b1;
      tick(); tick();
      wb_rst_ni = 1'b0;
      repeat (3) begin
         check_cycle();
         chk("t1_s_cyc", 32'(s_cyc), 32'd0);
         chk("t1_ack0", 32'(ack_o[0]), 32'd0);
         advance();
      end
      wb_rst_ni = 1'b1; s_ack = 1'b0;
      check_cycle();
      chk("t1_idle_after_rst", 32'(s_cyc), 32'd0);
      advance();
      check_cycle();
      chk("t1_regrant", 32'(s_cyc), 32'd1);
      advance();
      cti[0] = CTI_EOB; s_ack = 1'b1;
      tick();
      s_ack = 1'b0; cyc = 2'b00; stb = 2'b00;
      tick();

      // 2: m0 classic read from 0x10
      adr[0] = 32'h10; cti[0] = CTI_CLASSIC; bte[0] = BTE_LIN; we[0] = 1'b0;
      cyc = 2'b01; stb = 2'b01;
      check_cycle();
      chk("t2_arb_latency", 32'(s_cyc), 32'd0);
      advance();
      s_ack = 1'b1; s_dat_i = 32'hDEADBEEF;
      check_cycle();
      chk("t2_s_cyc", 32'(s_cyc), 32'd1);
      chk("t2_rdata", m0_dat, 32'hDEADBEEF);
      chk("t2_ack0", 32'(ack_o[0]), 32'd1);
      chk("t2_ack1", 32'(ack_o[1]), 32'd0);
      advance();
      s_ack = 1'b0; cyc = 2'b00; stb = 2'b00;
      tick();

      // 3: simultaneous requests after reset, then zero-gap handover
      wb_rst_ni = 1'b0; tick(); wb_rst_ni = 1'b1;
      adr[0] = 32'hA0; adr[1] = 32'hB0; bte[1] = BTE_WRAP8; cyc = 2'b11; stb = 2'b11;
      tick();
      check_cycle();
      chk("t3_first_m0", s_adr, 32'hA0);
      advance();
      s_ack = 1'b1; tick();
      s_ack = 1'b0; cyc[0] = 1'b0; stb[0] = 1'b0;
      tick();
      check_cycle();
      chk("t3_handover_adr", s_adr, 32'hB0);
      chk("t3_handover_cyc", 32'(s_cyc), 32'd1);
      advance();
      s_ack = 1'b1; tick();
      s_ack = 1'b0; cyc = 2'b00; stb = 2'b00;
      tick();

      // 4: m1 waits through an m0 4-beat incrementing burst
      bte[0] = BTE_WRAP16; adr[1] = 32'h300; cyc = 2'b01; stb = 2'b01;
      tick();
      cyc = 2'b11; stb = 2'b11; s_ack = 1'b1;
      for (int b = 0; b < 4; b++) begin
         cti[0] = (b < 3) ? CTI_INCR : CTI_EOB;
         adr[0] = 32'h200 + 32'(4 * b);
         check_cycle();
         chk("t4_ack0", 32'(ack_o[0]), 32'd1);
         chk("t4_ack1", 32'(ack_o[1]), 32'd0);
         advance();
      end
      s_ack = 1'b0;
      check_cycle();
      chk("t4_hold_after_eob", s_adr, 32'h20C);
      advance();
      cyc[0] = 1'b0; stb[0] = 1'b0;
      tick();
      s_ack = 1'b1;
      check_cycle();
      chk("t4_m1_adr", s_adr, 32'h300);
      chk("t4_m1_ack", 32'(ack_o[1]), 32'd1);
      advance();
      s_ack = 1'b0; cyc = 2'b00; stb = 2'b00;
      tick();

      // 5: slave never answers -> one-cycle watchdog err, slave cut off until cyc drops
      cti[0] = CTI_CLASSIC; cyc = 2'b01; stb = 2'b01;
      tick();
      for (int k = 0; k < int'(TO); k++) begin
         check_cycle();
         chk("t5_no_err_yet", 32'(err_o[0]), 32'd0);
         chk("t5_stb_live", 32'(s_stb), 32'd1);
         advance();
      end
      check_cycle();
      chk("t5_err_pulse", 32'(err_o[0]), 32'd1);
      chk("t5_stb_cut", 32'(s_stb), 32'd0);
      advance();
      repeat (3) begin
         check_cycle();
         chk("t5_err_single", 32'(err_o[0]), 32'd0);
         chk("t5_stb_held_off", 32'(s_stb), 32'd0);
         chk("t5_cyc_held_off", 32'(s_cyc), 32'd0);
         advance();
      end
      cyc = 2'b00; stb = 2'b00;
      tick();

      // 6a: ack arrives exactly on the terminal watchdog cycle
      cyc = 2'b01; stb = 2'b01;
      repeat (int'(TO) + 1) tick();
      s_ack = 1'b1;
      check_cycle();
      chk("t6_ack_wins", 32'(ack_o[0]), 32'd1);
      chk("t6_no_err", 32'(err_o[0]), 32'd0);
      advance();
      s_ack = 1'b0; cyc = 2'b00; stb = 2'b00;
      tick();

      // 6b: both masters always requesting -> grants alternate
      prev = -1;
      for (int n = 0; n < 100; n++) begin
         cyc = 2'b11; stb = 2'b11;
         adr[0] = $urandom; adr[1] = $urandom;
         got = -1;
         for (int k = 0; k < 20 && got < 0; k++) begin
            s_ack = ($urandom_range(0, 2) != 0);
            s_dat_i = $urandom;
            check_cycle();
            if (ack_o[0]) got = 0;
            else if (ack_o[1]) got = 1;
            advance();
         end
         chk("rr_ack_seen", 32'(got >= 0), 32'd1);
         if (prev >= 0 && got >= 0) chk("rr_alternate", 32'(got), 32'(prev ^ 1));
         if (got >= 0) begin
            s_ack = 1'b0; cyc[got] = 1'b0; stb[got] = 1'b0;
            tick();
            prev = got;
         end
      end
      s_ack = 1'b0; cyc = 2'b00; stb = 2'b00;
      tick();

      // Random traffic with stall windows
      stall_mode = 1'b0;
      for (int n = 0; n < 400; n++) begin
         if (n % 40 == 0) stall_mode = ($urandom_range(0, 2) == 0);
         for (int i = 0; i < 2; i++) begin
            if ($urandom_range(0, 5) == 0) cyc[i] = ~cyc[i];
            stb[i]  = cyc[i] & (stall_mode | 1'($urandom));
            adr[i]  = $urandom;
            wdat[i] = $urandom;
            sel[i]  = 4'($urandom);
            bte[i]  = 2'($urandom);
            cti[i]  = 3'($urandom);
            we[i]   = 1'($urandom);
         end
         s_ack = !stall_mode && 1'($urandom);
         s_err = !stall_mode && ($urandom_range(0, 15) == 0);
         s_rty = !stall_mode && ($urandom_range(0, 15) == 0);
         s_dat_i = $urandom;
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
